// File: rtl/poly_pkg.sv
// Shared types and sizes for the PolyMult frame loader.
// POLY_LOADER_CSUM_EN lengthens the frame by one trailing XOR checksum byte.
package poly_pkg;

  localparam int COEF_W = 8;
  localparam int N_COEF = 4;
`ifdef POLY_LOADER_CSUM_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif
  // Wide enough to address the optional checksum byte as well.
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2,
    CHECK  = 2'd3
  } poly_ld_state_t;

endpackage

// File: rtl/poly_frame_loader_if.sv
// Byte streams plus the PolyMult coefficient/result bus around the loader.
// The loader is the slave; the parent (or bench) is the master.
interface poly_frame_loader_if;
  import poly_pkg::*;

  logic              in_valid;
  logic [COEF_W-1:0] in_data;
  logic              in_ready;
  logic [COEF_W-1:0] a0, a1, a2, a3;
  logic [COEF_W-1:0] b0, b1, b2, b3;
  logic [COEF_W-1:0] c0, c1, c2, c3;
  logic              out_valid;
  logic [COEF_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  in_valid, in_data, c0, c1, c2, c3, out_ready,
    output in_ready, a0, a1, a2, a3, b0, b1, b2, b3,
           out_valid, out_data, busy, done, err
  );

  modport master (
    output in_valid, in_data, c0, c1, c2, c3, out_ready,
    input  in_ready, a0, a1, a2, a3, b0, b1, b2, b3,
           out_valid, out_data, busy, done, err
  );

endinterface

// File: rtl/poly_frame_loader.sv
// Serial loader for PolyMult: collects A/B coefficient bytes, waits a settle time,
// then streams C0..C3 out. Optional checksum byte under POLY_LOADER_CSUM_EN.
module poly_frame_loader
  import poly_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  poly_frame_loader_if.slave bus
);

  poly_ld_state_t    state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [1:0]        oidx_reg, oidx_next;
  logic              done_reg, done_next;
  logic              capture;
  logic              in_hs;

  logic [COEF_W-1:0] coef_reg [2*N_COEF];
  logic [COEF_W-1:0] res_reg  [N_COEF];
  logic [COEF_W-1:0] c_vec    [N_COEF];

`ifdef POLY_LOADER_CSUM_EN
  logic [COEF_W-1:0] csum_reg, csum_next;
  logic [COEF_W-1:0] chk_reg, chk_next;
  logic              err_reg, err_next;
`endif

  assign in_hs = bus.in_valid && (state_reg == LOAD);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    oidx_next  = oidx_reg;
    done_next  = 1'b0;
    capture    = 1'b0;
`ifdef POLY_LOADER_CSUM_EN
    csum_next  = csum_reg;
    chk_next   = chk_reg;
    err_next   = 1'b0;
`endif
    case (state_reg)
      LOAD: begin
        if (in_hs) begin
`ifdef POLY_LOADER_CSUM_EN
          // Restart the running XOR on the first byte so no frame leaks into the next.
          if (idx_reg == '0)
            csum_next = bus.in_data;
          else if (idx_reg < IDX_W'(FRAME_LEN - 1))
            csum_next = csum_reg ^ bus.in_data;
          else
            chk_next = bus.in_data;
`endif
          if (idx_reg == IDX_W'(FRAME_LEN - 1)) begin
            idx_next = '0;
`ifdef POLY_LOADER_CSUM_EN
            state_next = CHECK;
`else
            state_next = SETTLE;
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_reg == 4'(SETTLE_CYCLES - 1)) begin
          cnt_next   = '0;
          capture    = 1'b1;
          state_next = SEND;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (oidx_reg == 2'd3) begin
            oidx_next  = '0;
            done_next  = 1'b1;
            state_next = LOAD;
          end else begin
            oidx_next = oidx_reg + 1'b1;
          end
        end
      end
`ifdef POLY_LOADER_CSUM_EN
      CHECK: begin
        if (csum_reg == chk_reg) begin
          state_next = SETTLE;
        end else begin
          err_next   = 1'b1;
          state_next = LOAD;
        end
      end
`endif
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      oidx_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      oidx_reg  <= oidx_next;
      done_reg  <= done_next;
    end
  end

`ifdef POLY_LOADER_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_reg <= '0;
      chk_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      csum_reg <= csum_next;
      chk_reg  <= chk_next;
      err_reg  <= err_next;
    end
  end
  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

  // Checksum byte index (8) matches no coefficient slot, so it is never stored.
  genvar gi;
  generate
    for (gi = 0; gi < 2*N_COEF; gi++) begin : g_coef
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          coef_reg[gi] <= '0;
        else if (in_hs && (idx_reg == IDX_W'(gi)))
          coef_reg[gi] <= bus.in_data;
      end
    end
    for (gi = 0; gi < N_COEF; gi++) begin : g_res
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          res_reg[gi] <= '0;
        else if (capture)
          res_reg[gi] <= c_vec[gi];
      end
    end
  endgenerate

  assign c_vec[0] = bus.c0;
  assign c_vec[1] = bus.c1;
  assign c_vec[2] = bus.c2;
  assign c_vec[3] = bus.c3;

  assign bus.a0 = coef_reg[0];
  assign bus.a1 = coef_reg[1];
  assign bus.a2 = coef_reg[2];
  assign bus.a3 = coef_reg[3];
  assign bus.b0 = coef_reg[4];
  assign bus.b1 = coef_reg[5];
  assign bus.b2 = coef_reg[6];
  assign bus.b3 = coef_reg[7];

  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.out_valid = (state_reg == SEND);
  assign bus.out_data  = res_reg[oidx_reg];
  assign bus.busy      = (state_reg != LOAD) || (idx_reg != '0);
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_poly_frame_loader.sv
module tb_poly_frame_loader;
    import poly_pkg::*;

`ifdef POLY_LOADER_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_frame_loader_if bus0();
    poly_frame_loader_if bus1();

    poly_frame_loader #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    poly_frame_loader #(.SETTLE_CYCLES(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.c0 = bus0.a0 ^ bus0.b0;
    assign bus0.c1 = bus0.a1 ^ bus0.b1;
    assign bus0.c2 = bus0.a2 ^ bus0.b2;
    assign bus0.c3 = bus0.a3 ^ bus0.b3;
    assign bus1.c0 = bus1.a0 ^ bus1.b0;
    assign bus1.c1 = bus1.a1 ^ bus1.b1;
    assign bus1.c2 = bus1.a2 ^ bus1.b2;
    assign bus1.c3 = bus1.a3 ^ bus1.b3;

    int total = 0;
    int bad   = 0;
    int done0 = 0, err0 = 0, hs0 = 0, ovc0 = 0;

    always @(negedge clk) begin
        if (bus0.done) done0++;
        if (bus0.err) err0++;
        if (bus0.out_valid) ovc0++;
        if (bus0.out_valid && bus0.out_ready) hs0++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send0(input logic [7:0] d);
        logic hs;
        int n;
        n = 0;
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        do begin
            hs = bus0.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 50);
        bus0.in_valid = 1'b0;
        if (!hs) check("send_timeout", hs, 1'b1);
    endtask

    task automatic send_frame0(input logic [7:0] f [8], input logic [7:0] cs_mod);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send0(f[i]);
            x = x ^ f[i];
        end
        if (CS == 1) send0(x ^ cs_mod);
    endtask

    task automatic wait_ov0(output int edges);
        edges = 1;
        while (!bus0.out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("wait_ov0_expired", bus0.out_valid, 1'b1);
    endtask

    task automatic recv0(input logic [7:0] e [4], input bit toggle);
        int got, cyc;
        logic [7:0] held;
        bit stalled;
        got = 0; cyc = 0; stalled = 0; held = 8'h00;
        while (got < 4 && cyc < 40) begin
            bus0.out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (stalled) check("stall_hold", bus0.out_data, held);
            if (bus0.out_valid) begin
                check("in_ready_send", bus0.in_ready, 1'b0);
                if (bus0.out_ready) begin
                    check("out_data", bus0.out_data, e[got]);
                    $display("rx byte %0d = %02h", got, bus0.out_data);
                    got++;
                    stalled = 0;
                end else begin
                    held = bus0.out_data;
                    stalled = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus0.out_ready = 1'b0;
        if (!toggle) check("consecutive", cyc, 4);
        check("recv_count", got, 4);
    endtask

    logic [7:0] f_basic [8];
    logic [7:0] f_ff    [8];
    logic [7:0] f_gap   [8];
    logic [7:0] e_basic [4];
    logic [7:0] e_ff    [4];
    logic [7:0] e_gap   [4];
    int lat, d_before, hs_before, ov_before, e_before;
    logic [7:0] x1;

    initial begin
        f_basic = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
        e_basic = '{8'h11, 8'h22, 8'h33, 8'h44};
        f_ff    = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
        e_ff    = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
        f_gap   = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        e_gap   = '{8'h0F, 8'h0D, 8'h0B, 8'h05};

        bus0.in_valid = 1'b0; bus0.in_data = 8'h00; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus0.in_ready, 1'b1);
        check("rst_out_valid", bus0.out_valid, 1'b0);
        check("rst_out_data", bus0.out_data, 8'h00);
        check("rst_busy", bus0.busy, 1'b0);
        check("rst_done", bus0.done, 1'b0);
        check("rst_err", bus0.err, 1'b0);
        check("rst_a0", bus0.a0, 8'h00);
        check("rst_b3", bus0.b3, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        send0(f_basic[0]);
        check("busy_mid", bus0.busy, 1'b1);
        d_before = done0;
        for (int i = 1; i < 8; i++) send0(f_basic[i]);
        if (CS == 1) send0(8'h44);
        check("a_regs", {bus0.a0, bus0.a1, bus0.a2, bus0.a3}, 32'h01020304);
        check("b_regs", {bus0.b0, bus0.b1, bus0.b2, bus0.b3}, 32'h10203040);
        wait_ov0(lat);
        check("latency_basic", lat, 3 + CS);
        $display("basic frame latency %0d edges", lat);
        recv0(e_basic, 1'b0);
        check("done_pulse", bus0.done, 1'b1);
        check("in_ready_after", bus0.in_ready, 1'b1);
        check("busy_after", bus0.busy, 1'b0);
        @(posedge clk); #1;
        check("done_once", done0 - d_before, 1);

        send_frame0(f_basic, 8'h00);
        wait_ov0(lat);
        check("latency_bp", lat, 3 + CS);
        recv0(e_basic, 1'b1);
        check("bp_in_ready_after", bus0.in_ready, 1'b1);

        for (int i = 0; i < 5; i++) send0(f_basic[i]);
        check("busy_partial", bus0.busy, 1'b1);
        hs_before = hs0;
        rst = 1'b1;
        #1;
        check("abort_a0", bus0.a0, 8'h00);
        check("abort_b0", bus0.b0, 8'h00);
        check("abort_busy", bus0.busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame0(f_ff, 8'h00);
        wait_ov0(lat);
        check("latency_ff", lat, 3 + CS);
        recv0(e_ff, 1'b0);
        check("abort_hs_count", hs0 - hs_before, 4);

        x1 = 8'h00;
        for (int i = 0; i < 8 + CS; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            bus1.in_valid = 1'b1;
            bus1.in_data  = (i < 8) ? f_gap[i] : x1;
            if (i < 8) x1 = x1 ^ f_gap[i];
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
        end
        check("gap_a_regs", {bus1.a0, bus1.a1, bus1.a2, bus1.a3}, 32'h05060708);
        check("gap_b_regs", {bus1.b0, bus1.b1, bus1.b2, bus1.b3}, 32'h0A0B0C0D);
        lat = 1;
        while (!bus1.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("gap_wait_expired", bus1.out_valid, 1'b1);
        check("latency_gap", lat, 6 + CS);
        $display("gap frame latency %0d edges", lat);
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("gap_out_valid", bus1.out_valid, 1'b1);
            check("gap_out_data", bus1.out_data, e_gap[k]);
            $display("gap rx byte %0d = %02h", k, bus1.out_data);
            @(posedge clk); #1;
        end
        bus1.out_ready = 1'b0;
        check("gap_done", bus1.done, 1'b1);

`ifdef POLY_LOADER_CSUM_EN
        e_before  = err0;
        ov_before = ovc0;
        send_frame0(f_basic, 8'h01);
        repeat (10) @(posedge clk);
        #1;
        check("csum_err_once", err0 - e_before, 1);
        check("csum_no_output", ovc0 - ov_before, 0);
        check("csum_in_ready", bus0.in_ready, 1'b1);
        check("csum_busy", bus0.busy, 1'b0);
        send_frame0(f_basic, 8'h00);
        wait_ov0(lat);
        check("csum_latency", lat, 4);
        recv0(e_basic, 1'b0);
`else
        check("no_err_ever", err0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
